imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Decode-stage immediate generator: extracts and sign/zero-extends every RV32I immediate format.
//  Registered output sits behind a 2-entry skid buffer with valid/ready on both sides,
//  so the fetch->decode boundary can stall or flush without losing instructions.
//  A tag (PC/ROB id) travels alongside each immediate.
// PARAMETERS
//  WIDTH   32  datapath / output width; must be >= 32; extension fills bits WIDTH-1:32
//  TAG_W   32  width of the sideband tag carried with each entry
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active low
//  flush      in   1      synchronous discard of all buffered entries
//  in_valid   in   1      instr/imm_src/in_tag valid
//  in_ready   out  1      buffer can accept this cycle
//  instr      in   32     raw instruction word
//  imm_src    in   3      format select (see BEHAVIOUR)
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer accepts head
//  imm_out    out  WIDTH  extended immediate of head entry
//  out_tag    out  TAG_W  tag of head entry
//  illegal    out  1      head entry used a reserved imm_src code
// BEHAVIOUR
//  Formats (s = instr[31] replicated to WIDTH):
//   000 I : s, instr[31:20]
//   001 S : s, instr[31:25], instr[11:7]
//   010 B : s, instr[7], instr[30:25], instr[11:8], 1'b0
//   011 J : s, instr[19:12], instr[20], instr[30:21], 1'b0
//   100 U : s above bit 31, instr[31:12], 12'b0
//   101 SHAMT : zero-extended instr[24:20]
//   110 ZIMM  : zero-extended instr[19:15] (CSR immediate)
//   111 reserved : imm = 0, illegal = 1 stored with the entry
//  Buffer: 2 entries, head/tail pointers, count 0..2.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  in_ready = (count != 2), driven from registered state only (no in->out comb path).
//  out_valid = (count != 0); imm_out/out_tag/illegal = head entry, zero when count == 0.
//  Latency: accepted instr appears at outputs the next cycle if buffer was empty.
//  Order strictly FIFO; entries never overwritten while valid.
//  count 1, push & pop same cycle: count stays 1, new entry becomes head next cycle.
//  count 2: in_ready = 0, push impossible; pop frees one slot, in_ready = 1 next cycle.
//  count 0: pop ignored (out_valid = 0).
//  Pointers wrap 1 -> 0.
//  flush: count, pointers -> 0 next cycle; overrides same-cycle push and pop
//   (pushed instr is dropped; popped entry counts as consumed by the consumer only).
//  rst_n = 0 at a clock edge: count = 0, pointers = 0, out_valid = 0, in_ready = 1 after edge,
//   imm_out = 0, out_tag = 0, illegal = 0; mid-stall reset discards all entries.
//  Inputs sampled only when push; instr/imm_src/in_tag may change freely otherwise.
// TESTING
//  I: instr 0xFFF00093, src 000, out_ready=1 -> next cycle out_valid=1, imm_out 0xFFFFFFFF
//  S/B: 0xFE20AE23 src 001 -> 0xFFFFFFFC; 0xFE000CE3 src 010 -> 0xFFFFFFF8
//  U/J/ZIMM: 0x123450B7 src 100 -> 0x12345000; 0xFFDFF06F src 011 -> 0xFFFFFFFC;
//    0x0002D073 src 110 -> 0x00000005; src 111 -> imm 0, illegal 1
//  Backpressure: out_ready=0, push tags 1,2,3 back-to-back -> in_ready 0 after 2nd;
//    tag 3 held at input; release out_ready -> out_tag 1,2,3 in order, no loss/dup
//  Flush: count 2, assert flush with in_valid=1 -> next cycle out_valid 0, in_ready 1,
//    flushed-cycle instr never appears
//  Reset: rst_n low for 1 cycle with count 2 -> out_valid 0, imm_out 0, in_ready 1 after edge
//  WIDTH=64 build: src 000 instr 0x80000013 -> imm_out 0xFFFFFFFFFFFFF800

Source files
------------

// File: rtl/imm_extend_pipe.sv
// RV32I decode-stage immediate generator with a 2-entry skid buffer on the output.
// Each buffered entry carries the extended immediate, a sideband tag and an illegal-format flag.
module imm_extend_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  logic [31:0]      imm32;
  logic             imm_sext;
  logic             imm_ill;
  logic [WIDTH-1:0] imm_ext;

  // Build the 32-bit immediate first, then fill WIDTH-1:32 so WIDTH == 32 needs no special case.
  always_comb begin
    imm32    = '0;
    imm_sext = 1'b1;
    imm_ill  = 1'b0;
    case (imm_src)
      SRC_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      SRC_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SRC_U:     imm32 = {instr[31:12], 12'b0};
      SRC_SHAMT: begin
        imm32    = {27'b0, instr[24:20]};
        imm_sext = 1'b0;
      end
      SRC_ZIMM:  begin
        imm32    = {27'b0, instr[19:15]};
        imm_sext = 1'b0;
      end
      default:   begin
        imm32    = '0;
        imm_sext = 1'b0;
        imm_ill  = 1'b1;
      end
    endcase
    imm_ext        = {WIDTH{imm_sext & imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] ent_imm_q [2];
  logic [TAG_W-1:0] ent_tag_q [2];
  logic             ent_ill_q [2];
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign imm_out = out_valid ? ent_imm_q[head_q] : '0;
  assign out_tag = out_valid ? ent_tag_q[head_q] : '0;
  assign illegal = out_valid ? ent_ill_q[head_q] : 1'b0;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) begin
      ent_imm_q[tail_q] <= imm_ext;
      ent_tag_q[tail_q] <= in_tag;
      ent_ill_q[tail_q] <= imm_ill;
    end
  end

endmodule
